ble_crc24_engine: RTL and testbench
===================================

Name: ble_crc24_engine

Overview:
- Serial BLE CRC-24 stage directly downstream of the TX/RX CRC bit FIFO. It consumes the FIFO's one-bit data_out/valid_out stream.
- TX mode: passes the PDU bits through, then appends the 24-bit CRC.
- RX mode: passes the PDU bits through, absorbs the 24 received CRC bits and flags pass/fail.
- Sits between the bit FIFO and the GFSK modulator/demodulator interface of the BLE PHY.

Parameters:
- LEN_W, 12, width of the PDU bit-count input (max 4095 PDU bits).
- CRC_INIT_DEF, 24'h555555, CRC seed used when crc_init_sel=0 (advertising-channel seed).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; latches mode, bit_count, seed; ignored while busy=1
- mode  input  1  0=TX generate, 1=RX check
- crc_init_sel  input  1  0=CRC_INIT_DEF, 1=crc_init
- crc_init  input  24  connection-specific CRC seed
- bit_count  input  LEN_W  number of PDU bits preceding the CRC
- bit_in  input  1  serial bit from the FIFO data_out
- bit_valid  input  1  qualifies bit_in (FIFO valid_out)
- bit_out  output  1  serial output bit
- bit_out_valid  output  1  qualifies bit_out
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle completion pulse
- crc_ok  output  1  RX result, valid from done until the next start
- crc_value  output  24  live CRC register
- overrun  output  1  sticky; bit_valid seen during CRC_OUT

Behaviour:
- Reset values: all outputs 0. crc register=0, state=IDLE, counters=0.
- States: IDLE, DATA, CRC_OUT (TX), CRC_IN (RX), FIN.
- IDLE + start:
  - load c=seed, cnt=0, latch mode and bit_count.
  - Next state: DATA, or if bit_count==0 go straight to CRC_OUT (TX) or CRC_IN (RX).
- LFSR update on each accepted bit b:
  - fb = b ^ c[23]
  - c <= {c[22:0],1'b0} ^ (fb ? 24'h00065B : 0)
  - polynomial x^24+x^10+x^9+x^6+x^4+x^3+x+1.
- DATA:
  - each bit_valid cycle: update LFSR, cnt+1.
  - bit_out<=bit_in, bit_out_valid<=1, registered with 1-cycle latency.
  - no valid: bit_out_valid<=0, state holds.
  - On the bit where cnt==bit_count-1: go to CRC_OUT (TX) or CRC_IN (RX).
- CRC_OUT (TX):
  - 24 consecutive cycles, no stalls.
  - bit_out<=c[23], bit_out_valid<=1, c<={c[22:0],0} (MSB first).
  - Output timing: last PDU bit accepted at cycle N appears on bit_out at N+1; CRC bits at N+2..N+25.
  - bit_valid during CRC_OUT: bit dropped, overrun<=1 (cleared only by start or reset).
  - After 24 bits go to FIN.
- CRC_IN (RX):
  - next 24 bit_valid bits feed the LFSR exactly as in DATA.
  - bit_out_valid stays 0; CRC bits are stripped.
  - After 24 bits go to FIN.
- FIN:
  - done=1 for one cycle, busy<=0.
  - crc_ok<=(c==0) in RX mode; crc_ok=0 in TX mode.
  - Return to IDLE.
- bit_valid in IDLE/FIN: ignored, no state change.
- start while busy: ignored, no error.
- start and bit_valid in the same cycle in IDLE: the bit is ignored; the first PDU bit is counted from the next cycle.
- Count comparisons are LEN_W-bit unsigned; the CRC bit counter is 5 bits, 0..23.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0; the partial frame is discarded.

Optional Feature:
- Macro: BLE_CRC_WHITEN_EN.
- Ports added when defined: whiten_seed (input, 7, channel index with bit 6 forced to 1).
- Whitening register: 7-bit w, loaded with {1'b1, whiten_seed[5:0]} on start.
  - Per whitened bit: wb=w[6]; w<={w[5:3], w[2]^wb, w[1:0], wb} (x^7+x^4+1).
- TX: PDU and CRC bits on bit_out are XORed with wb; the LFSR uses the unwhitened bits.
- RX: bit_in is XORed with wb before both the LFSR and bit_out.
- Not defined: no whiten_seed port, no whitening logic; bit streams are unmodified.

Test Plan:
- TX, bit_count=0, crc_init_sel=0, start -> 24 bit_out bits 0,1,0,1,... (0x555555 MSB first), done one cycle after the last bit, crc_ok=0.
- TX, crc_init_sel=1, crc_init=0, bit_count=1, bit_in=1 -> bit_out 1 then 0x00065B MSB first (000000000000011001011011), crc_value=0 at done.
- RX, seed 0, bit_count=1, feed 1 then 0x00065B MSB first -> no bit_out_valid during CRC bits, done, crc_ok=1. Same run with the last bit flipped -> crc_ok=0.
- TX, 16-bit PDU 0xA5C3 with gapped bit_valid -> bit_out mirrors bit_in 1 cycle later. The CRC matches the reference model. A bit_valid pulse during CRC_OUT sets overrun=1; the next start clears it.
- Reset asserted during the 10th CRC_OUT cycle -> all outputs 0 next edge. A new start with bit_count=0 reproduces the 0x555555 sequence.
- BLE_CRC_WHITEN_EN, whiten_seed=7'h65 (channel 37), TX 8-bit PDU -> bit_out equals the model's whitened stream. Looping it back in RX with the same seed -> crc_ok=1.

Source files
------------

// File: rtl/ble_crc24_if.sv
// Bit-stream and control bundle for the BLE CRC-24 engine.
// Carries whiten_seed only when BLE_CRC_WHITEN_EN is defined.
interface ble_crc24_if #(
    parameter int LEN_W = 12
);
    logic             start;
    logic             mode;
    logic             crc_init_sel;
    logic [23:0]      crc_init;
    logic [LEN_W-1:0] bit_count;
    logic             bit_in;
    logic             bit_valid;
`ifdef BLE_CRC_WHITEN_EN
    logic [6:0]       whiten_seed;
`endif
    logic             bit_out;
    logic             bit_out_valid;
    logic             busy;
    logic             done;
    logic             crc_ok;
    logic [23:0]      crc_value;
    logic             overrun;

    modport master (
        output start, mode, crc_init_sel, crc_init,
        output bit_count, bit_in, bit_valid,
`ifdef BLE_CRC_WHITEN_EN
        output whiten_seed,
`endif
        input  bit_out, bit_out_valid, busy, done,
        input  crc_ok, crc_value, overrun
    );

    modport slave (
        input  start, mode, crc_init_sel, crc_init,
        input  bit_count, bit_in, bit_valid,
`ifdef BLE_CRC_WHITEN_EN
        input  whiten_seed,
`endif
        output bit_out, bit_out_valid, busy, done,
        output crc_ok, crc_value, overrun
    );
endinterface

// File: rtl/ble_crc24_engine.sv
// Serial BLE CRC-24 generate/check stage between the CRC bit FIFO and the PHY.
// Optional data whitening (x^7+x^4+1) is enabled by defining BLE_CRC_WHITEN_EN.
module ble_crc24_engine #(
    parameter int          LEN_W        = 12,
    parameter logic [23:0] CRC_INIT_DEF = 24'h555555
) (
    input  logic       clk,
    input  logic       reset,
    ble_crc24_if.slave bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DATA    = 3'd1;
    localparam logic [2:0] S_CRC_OUT = 3'd2;
    localparam logic [2:0] S_CRC_IN  = 3'd3;
    localparam logic [2:0] S_FIN     = 3'd4;

    localparam logic [23:0] POLY = 24'h00065B;

    logic [2:0]       r_state;
    logic [23:0]      r_crc;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] r_len;
    logic [4:0]       r_ccnt;
    logic             r_mode;
    logic             r_bit_out;
    logic             r_bit_out_valid;
    logic             r_busy;
    logic             r_done;
    logic             r_crc_ok;
    logic             r_overrun;

    logic             w_wb;
    logic             w_lfsr_bit;
    logic             w_last_pdu;
    logic             w_last_crc;
    logic [2:0]       w_tail_state;

    function automatic logic [23:0] f_step(
        input logic [23:0] c,
        input logic        b
    );
        logic fb;
        fb = b ^ c[23];
        return {c[22:0], 1'b0} ^ (fb ? POLY : 24'h0);
    endfunction

`ifdef BLE_CRC_WHITEN_EN
    logic [6:0] r_w;
    logic       w_adv;

    assign w_wb  = r_w[6];
    assign w_adv = ((r_state == S_DATA) && bus.bit_valid)
                 || (r_state == S_CRC_OUT)
                 || ((r_state == S_CRC_IN) && bus.bit_valid);

    // Bit 6 of the seed is always forced high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_w <= '0;
        end else if ((r_state == S_IDLE) && bus.start) begin
            r_w <= bus.whiten_seed | 7'h40;
        end else if (w_adv) begin
            r_w <= {r_w[5:3], r_w[2] ^ r_w[6], r_w[1:0], r_w[6]};
        end
    end
`else
    assign w_wb = 1'b0;
`endif

    // RX de-whitens before the LFSR; TX feeds the raw PDU bit.
    assign w_lfsr_bit   = bus.bit_in ^ (r_mode & w_wb);
    assign w_last_pdu   = (r_cnt == (r_len - LEN_W'(1)));
    assign w_last_crc   = (r_ccnt == 5'd23);
    assign w_tail_state = r_mode ? S_CRC_IN : S_CRC_OUT;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_crc           <= '0;
            r_cnt           <= '0;
            r_len           <= '0;
            r_ccnt          <= '0;
            r_mode          <= 1'b0;
            r_bit_out       <= 1'b0;
            r_bit_out_valid <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_crc_ok        <= 1'b0;
            r_overrun       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_bit_out_valid <= 1'b0;
                    if (bus.start) begin
                        r_crc     <= bus.crc_init_sel ? bus.crc_init
                                                      : CRC_INIT_DEF;
                        r_cnt     <= '0;
                        r_ccnt    <= '0;
                        r_mode    <= bus.mode;
                        r_len     <= bus.bit_count;
                        r_busy    <= 1'b1;
                        r_crc_ok  <= 1'b0;
                        r_overrun <= 1'b0;
                        if (bus.bit_count == '0) begin
                            r_state <= bus.mode ? S_CRC_IN : S_CRC_OUT;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    r_bit_out_valid <= bus.bit_valid;
                    if (bus.bit_valid) begin
                        r_bit_out <= bus.bit_in ^ w_wb;
                        r_crc     <= f_step(r_crc, w_lfsr_bit);
                        r_cnt     <= r_cnt + LEN_W'(1);
                        if (w_last_pdu) begin
                            r_state <= w_tail_state;
                        end
                    end
                end
                S_CRC_OUT: begin
                    r_bit_out       <= r_crc[23] ^ w_wb;
                    r_bit_out_valid <= 1'b1;
                    r_crc           <= {r_crc[22:0], 1'b0};
                    r_ccnt          <= r_ccnt + 5'd1;
                    if (bus.bit_valid) begin
                        r_overrun <= 1'b1;
                    end
                    if (w_last_crc) begin
                        r_ccnt  <= '0;
                        r_state <= S_FIN;
                    end
                end
                S_CRC_IN: begin
                    r_bit_out_valid <= 1'b0;
                    if (bus.bit_valid) begin
                        r_crc  <= f_step(r_crc, w_lfsr_bit);
                        r_ccnt <= r_ccnt + 5'd1;
                        if (w_last_crc) begin
                            r_ccnt  <= '0;
                            r_state <= S_FIN;
                        end
                    end
                end
                S_FIN: begin
                    r_bit_out_valid <= 1'b0;
                    r_done          <= 1'b1;
                    r_busy          <= 1'b0;
                    r_crc_ok        <= r_mode && (r_crc == 24'h0);
                    r_state         <= S_IDLE;
                end
                default: begin
                    r_bit_out_valid <= 1'b0;
                    r_state         <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.bit_out       = r_bit_out;
    assign bus.bit_out_valid = r_bit_out_valid;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.crc_ok        = r_crc_ok;
    assign bus.crc_value     = r_crc;
    assign bus.overrun       = r_overrun;
endmodule

// File: tb/tb_ble_crc24_engine.sv
// Directed-vector bench for ble_crc24_engine.
// Whitening vectors are included when BLE_CRC_WHITEN_EN is defined.
module tb_ble_crc24_engine;
    localparam int LEN_W = 12;

    typedef struct {
        logic             mode;
        logic             sel;
        logic [23:0]      init;
        logic [LEN_W-1:0] nbits;
        logic [31:0]      pdu;
        logic [23:0]      tail;
        logic             gap;
        logic             ovr;
        logic             noisy;
        logic [6:0]       wseed;
        logic [23:0]      exp_crc;
        logic             exp_ok;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ble_crc24_if #(.LEN_W(LEN_W)) bus ();

    ble_crc24_engine #(
        .LEN_W       (LEN_W),
        .CRC_INIT_DEF(24'h555555)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic q_out[$];
    int   q_out_cyc[$];
    int   q_in_cyc[$];
    bit   rec_in = 1'b0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    logic ok_at_done, ovr_at_done, busy_at_done;
    logic [23:0] crc_at_done;
    vec_t tv[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.bit_out_valid) begin
            q_out.push_back(bus.bit_out);
            q_out_cyc.push_back(cyc);
        end
        if (rec_in && bus.bit_valid) q_in_cyc.push_back(cyc);
        if (bus.done) begin
            done_cnt++;
            done_cyc     = cyc;
            ok_at_done   = bus.crc_ok;
            crc_at_done  = bus.crc_value;
            ovr_at_done  = bus.overrun;
            busy_at_done = bus.busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [23:0] m_crc(input logic [23:0] seed,
                                          input logic [31:0] pdu,
                                          input int n);
        logic [23:0] c;
        logic fb;
        c = seed;
        for (int i = n - 1; i >= 0; i--) begin
            fb = pdu[i] ^ c[23];
            c  = {c[22:0], 1'b0} ^ (fb ? 24'h00065B : 24'h0);
        end
        return c;
    endfunction

    function automatic logic [55:0] m_wseq(input logic [6:0] s);
        logic [6:0]  w;
        logic        wb;
        logic [55:0] r;
        w = {1'b1, s[5:0]};
        r = '0;
        for (int i = 0; i < 56; i++) begin
            wb        = w[6];
            r[55 - i] = wb;
            w         = {w[5:3], w[2] ^ wb, w[1:0], wb};
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic m, input logic s,
                                input logic [23:0] ini, input int n,
                                input logic [31:0] p, input logic [23:0] t,
                                input logic g, input logic o,
                                input logic nz, input logic [6:0] ws,
                                input logic [23:0] ec, input logic eo);
        vec_t v;
        v.mode = m; v.sel = s; v.init = ini; v.nbits = LEN_W'(n);
        v.pdu = p; v.tail = t; v.gap = g; v.ovr = o; v.noisy = nz;
        v.wseed = ws; v.exp_crc = ec; v.exp_ok = eo;
        return v;
    endfunction

    task automatic run_frame(input vec_t v, input string tag);
        int n;
        int total;
        int bad;
        logic b;
        logic [63:0] ap, ep;
        logic [55:0] ws;
        logic exp_q[$];
        n     = int'(v.nbits);
        total = n + (v.mode ? 24 : 0);
        q_out.delete();
        q_out_cyc.delete();
        q_in_cyc.delete();
        done_cnt = 0;
        if (v.noisy) begin
            bus.bit_in = 1'b1; bus.bit_valid = 1'b1;
            tick();
            bus.bit_valid = 1'b0;
        end
        bus.start        = 1'b1;
        bus.mode         = v.mode;
        bus.crc_init_sel = v.sel;
        bus.crc_init     = v.init;
        bus.bit_count    = v.nbits;
        bus.bit_valid    = v.noisy;
        bus.bit_in       = 1'b1;
`ifdef BLE_CRC_WHITEN_EN
        bus.whiten_seed  = v.wseed;
`endif
        tick();
        bus.start = 1'b0; bus.bit_valid = 1'b0; rec_in = 1'b1;
        chk({tag, "_busy_start"}, 64'(bus.busy), 64'd1);
        chk({tag, "_ovr_clear"}, 64'(bus.overrun), 64'd0);
        for (int i = 0; i < total; i++) begin
            if (v.gap && (i % 3 == 1)) begin
                bus.bit_valid = 1'b0;
                tick();
            end
            b = (i < n) ? v.pdu[n - 1 - i] : v.tail[23 - (i - n)];
            bus.bit_in = b; bus.bit_valid = 1'b1;
            if (v.noisy && i == 1) begin
                bus.start = 1'b1; bus.mode = ~v.mode;
                bus.bit_count = LEN_W'(5);
            end
            tick();
            bus.start = 1'b0; bus.mode = v.mode; bus.bit_count = v.nbits;
        end
        bus.bit_valid = 1'b0;
        if (v.ovr) begin
            repeat (3) tick();
            bus.bit_in = 1'b1; bus.bit_valid = 1'b1;
            tick();
            bus.bit_valid = 1'b0;
        end
        for (int k = 0; k < 300 && done_cnt == 0; k++) tick();
        rec_in = 1'b0;

        ws = '0;
`ifdef BLE_CRC_WHITEN_EN
        ws = m_wseq(v.wseed);
`endif
        for (int i = 0; i < n; i++) exp_q.push_back(v.pdu[n - 1 - i]);
        if (!v.mode)
            for (int i = 0; i < 24; i++) exp_q.push_back(v.exp_crc[23 - i]);
        foreach (exp_q[i]) exp_q[i] = exp_q[i] ^ ws[55 - i];
        ap = '0; ep = '0;
        foreach (q_out[i]) ap = {ap[62:0], q_out[i]};
        foreach (exp_q[i]) ep = {ep[62:0], exp_q[i]};

        chk({tag, "_done"}, 64'(done_cnt), 64'd1);
        chk({tag, "_out_len"}, 64'(q_out.size()), 64'(exp_q.size()));
        chk({tag, "_stream"}, ap, ep);
        chk({tag, "_crc_ok"}, 64'(ok_at_done), 64'(v.exp_ok));
        chk({tag, "_overrun"}, 64'(ovr_at_done), 64'(v.ovr));
        chk({tag, "_busy_done"}, 64'(busy_at_done), 64'd0);
        bad = 0;
        for (int i = 0; i < n; i++)
            if (i >= q_out_cyc.size() || i >= q_in_cyc.size()
                || q_out_cyc[i] != q_in_cyc[i] + 1) bad++;
        chk({tag, "_pdu_lat"}, 64'(bad), 64'd0);
        if (!v.mode) begin
            chk({tag, "_crc_zero"}, 64'(crc_at_done), 64'd0);
            if (q_out_cyc.size() > 0)
                chk({tag, "_done_lat"}, 64'(done_cyc - q_out_cyc[$]), 64'd1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout global time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [23:0] c16, c12, c8;
        logic [55:0] wsq;
        logic [31:0] wtx;

        reset = 1'b1;
        bus.start = 1'b0; bus.mode = 1'b0; bus.crc_init_sel = 1'b0;
        bus.crc_init = '0; bus.bit_count = '0;
        bus.bit_in = 1'b0; bus.bit_valid = 1'b0;
`ifdef BLE_CRC_WHITEN_EN
        bus.whiten_seed = '0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_outs", {bus.bit_out, bus.bit_out_valid, bus.busy,
                           bus.done, bus.crc_ok, bus.overrun,
                           bus.crc_value}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        c16 = m_crc(24'h555555, 32'hA5C3, 16);
        c12 = m_crc(24'h123456, 32'hABC, 12);
        tv.push_back(mk(0, 0, 24'h0, 0, 32'h0, 24'h0, 0, 0, 0, 7'h0,
                        24'h555555, 0));
        tv.push_back(mk(0, 1, 24'h0, 1, 32'h1, 24'h0, 0, 0, 0, 7'h0,
                        24'h00065B, 0));
        tv.push_back(mk(1, 1, 24'h0, 1, 32'h1, 24'h00065B, 0, 0, 0, 7'h0,
                        24'h0, 1));
        tv.push_back(mk(1, 1, 24'h0, 1, 32'h1, 24'h00065A, 0, 0, 0, 7'h0,
                        24'h0, 0));
        tv.push_back(mk(0, 0, 24'h0, 16, 32'hA5C3, 24'h0, 1, 1, 0, 7'h0,
                        c16, 0));
        tv.push_back(mk(1, 0, 24'h0, 16, 32'hA5C3, c16, 0, 0, 1, 7'h0,
                        24'h0, 1));
        tv.push_back(mk(0, 1, 24'h123456, 12, 32'hABC, 24'h0, 1, 0, 1,
                        7'h0, c12, 0));
        tv.push_back(mk(1, 1, 24'h123456, 12, 32'hABC, c12 ^ 24'h000020,
                        0, 0, 0, 7'h0, 24'h0, 0));
`ifdef BLE_CRC_WHITEN_EN
        c8  = m_crc(24'h555555, 32'h3C, 8);
        wsq = m_wseq(7'h65);
        wtx = {8'h3C, c8} ^ wsq[55:24];
        tv.push_back(mk(0, 0, 24'h0, 8, 32'h3C, 24'h0, 0, 0, 0, 7'h65,
                        c8, 0));
        tv.push_back(mk(1, 0, 24'h0, 8, {24'h0, wtx[31:24]}, wtx[23:0],
                        0, 0, 0, 7'h65, 24'h0, 1));
`else
        c8 = '0; wsq = '0; wtx = '0;
`endif

        foreach (tv[i]) run_frame(tv[i], $sformatf("v%0d", i));

        tick();
        bus.start = 1'b1; bus.mode = 1'b0; bus.crc_init_sel = 1'b0;
        bus.bit_count = '0;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        chk("busy_pre_rst", 64'(bus.busy), 64'd1);
        chk("obv_pre_rst", 64'(bus.bit_out_valid), 64'd1);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("rst_mid", {bus.bit_out, bus.bit_out_valid, bus.busy,
                        bus.done, bus.crc_ok, bus.overrun,
                        bus.crc_value}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        run_frame(tv[0], "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
